// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_if.sv
// Control/status bundle between the DAC sync controller and its software/link side.
// The slave modport is the controller's view; the master modport drives requests.
interface ad_ip_jesd204_tpl_dac_sync_ctrl_if #(
   parameter int DELAY_WIDTH   = 16,
   parameter int TIMEOUT_WIDTH = 32
);
   logic                     arm;
   logic                     disarm;
   logic                     manual_req;
   logic                     sync_in;
   logic                     link_ready;
   logic [DELAY_WIDTH-1:0]   delay;
   logic [TIMEOUT_WIDTH-1:0] timeout;
   logic                     clear_err;
   logic                     armed;
   logic                     datapath_en;
   logic                     sync_pulse;
   logic                     timeout_err;

   modport master (
      output arm, disarm, manual_req, sync_in, link_ready, delay, timeout, clear_err,
      input  armed, datapath_en, sync_pulse, timeout_err
   );

   modport slave (
      input  arm, disarm, manual_req, sync_in, link_ready, delay, timeout, clear_err,
      output armed, datapath_en, sync_pulse, timeout_err
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Arms the DAC datapath, waits for a sync trigger plus programmable delay, then releases it with a phase-reset strobe.
// All outputs registered (1 cycle after the deciding edge); no backpressure, every input is sampled each cycle.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
   parameter int EXT_SYNC      = 1,
   parameter int DELAY_WIDTH   = 16,
   parameter int TIMEOUT_WIDTH = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   ad_ip_jesd204_tpl_dac_sync_ctrl_if.slave   ctrl
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_DELAY = 2'd2
   } state_t;

   localparam bit                       EXT_EN  = (EXT_SYNC != 0);
   localparam logic [DELAY_WIDTH-1:0]   DLY_ONE = 1;
   localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE = 1;

   state_t                   state, state_nxt;
   logic [DELAY_WIDTH-1:0]   dly_cnt, dly_cnt_nxt;
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
   logic                     sync_in_d;
   logic                     trigger;
   logic                     tmo_hit;
   logic                     fire;
   logic                     tmo_evt;
   logic                     armed_q, dp_en_q, pulse_q, err_q;

   assign trigger = ctrl.link_ready &
                    (ctrl.manual_req | (EXT_EN & ctrl.sync_in & ~sync_in_d));

   // tmo_cnt holds completed ARMED cycles, so the T-th cycle is the one where it reads T-1
   assign tmo_hit = (ctrl.timeout != '0) && (tmo_cnt >= ctrl.timeout - TMO_ONE);

   always_comb begin
      state_nxt   = state;
      dly_cnt_nxt = dly_cnt;
      tmo_cnt_nxt = tmo_cnt;
      fire        = 1'b0;
      tmo_evt     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl.arm && !ctrl.disarm) begin
               state_nxt   = ST_ARMED;
               tmo_cnt_nxt = '0;
            end
         end
         ST_ARMED: begin
            if (ctrl.disarm) begin
               state_nxt = ST_IDLE;
            end else if (trigger) begin
               if (ctrl.delay == '0) begin
                  state_nxt = ST_IDLE;
                  fire      = 1'b1;
               end else begin
                  state_nxt   = ST_DELAY;
                  dly_cnt_nxt = ctrl.delay - DLY_ONE;
               end
            end else if (ctrl.arm) begin
               tmo_cnt_nxt = '0;
            end else if (tmo_hit) begin
               state_nxt = ST_IDLE;
               tmo_evt   = 1'b1;
            end else if (tmo_cnt != '1) begin
               tmo_cnt_nxt = tmo_cnt + TMO_ONE;
            end
         end
         ST_DELAY: begin
            if (ctrl.disarm) begin
               state_nxt = ST_IDLE;
            end else if (dly_cnt == '0) begin
               state_nxt = ST_IDLE;
               fire      = 1'b1;
            end else begin
               dly_cnt_nxt = dly_cnt - DLY_ONE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         dly_cnt   <= '0;
         tmo_cnt   <= '0;
         sync_in_d <= 1'b1;
         armed_q   <= 1'b0;
         dp_en_q   <= 1'b1;
         pulse_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         dly_cnt   <= dly_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         sync_in_d <= ctrl.sync_in;
         armed_q   <= (state_nxt != ST_IDLE);
         dp_en_q   <= (state_nxt == ST_IDLE);
         pulse_q   <= fire;
         if (tmo_evt)
            err_q <= 1'b1;
         else if (ctrl.clear_err)
            err_q <= 1'b0;
      end
   end

   assign ctrl.armed       = armed_q;
   assign ctrl.datapath_en = dp_en_q;
   assign ctrl.sync_pulse  = pulse_q;
   assign ctrl.timeout_err = err_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Drives two controllers (external sync enabled / disabled) with identical stimulus
// and scores their outputs against an event-level reference model.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

   typedef struct {
      bit rst, arm, dis, man, sync, link, clr;
      int dly, tmo;
   } stim_t;

   // mode: 0 released, 1 waiting for trigger, 2 waiting for release cycle
   typedef struct {
      int mode;
      int armed_cycles;
      int release_at;
      bit prev_sync;
      bit pulse;
      bit err;
   } mdl_t;

   typedef struct {
      int         due;
      logic [3:0] e1;
      logic [3:0] e0;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc_n = 0;
   int   total = 0;
   int   bad = 0;

   bit   g_sync = 1'b1;
   bit   g_link = 1'b1;
   int   g_dly = 0;
   int   g_tmo = 0;

   mdl_t m1, m0;
   exp_t sb[$];

   ad_ip_jesd204_tpl_dac_sync_ctrl_if #(.DELAY_WIDTH(16), .TIMEOUT_WIDTH(32)) b1 ();
   ad_ip_jesd204_tpl_dac_sync_ctrl_if #(.DELAY_WIDTH(16), .TIMEOUT_WIDTH(32)) b0 ();

   ad_ip_jesd204_tpl_dac_sync_ctrl #(.EXT_SYNC(1), .DELAY_WIDTH(16), .TIMEOUT_WIDTH(32)) dut1 (
      .clk   (clk),
      .reset (reset),
      .ctrl  (b1)
   );

   ad_ip_jesd204_tpl_dac_sync_ctrl #(.EXT_SYNC(0), .DELAY_WIDTH(16), .TIMEOUT_WIDTH(32)) dut0 (
      .clk   (clk),
      .reset (reset),
      .ctrl  (b0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic mdl_t step(mdl_t m_in, bit ext, int now, stim_t s);
      mdl_t m;
      bit   trig;
      bit   timed_out;
      m = m_in;
      if (s.rst) begin
         m.mode = 0;
         m.armed_cycles = 0;
         m.release_at = 0;
         m.prev_sync = 1'b1;
         m.pulse = 1'b0;
         m.err = 1'b0;
         return m;
      end
      trig = s.link && (s.man || (ext && s.sync && !m.prev_sync));
      m.prev_sync = s.sync;
      m.pulse = 1'b0;
      timed_out = 1'b0;
      if (m.mode == 0) begin
         if (s.arm && !s.dis) begin
            m.mode = 1;
            m.armed_cycles = 0;
         end
      end else if (m.mode == 1) begin
         m.armed_cycles++;
         if (s.dis) m.mode = 0;
         else if (trig) begin
            if (s.dly == 0) begin
               m.mode = 0;
               m.pulse = 1'b1;
            end else begin
               m.mode = 2;
               m.release_at = now + s.dly;
            end
         end else if (s.arm) m.armed_cycles = 0;
         else if (s.tmo != 0 && m.armed_cycles >= s.tmo) begin
            m.mode = 0;
            timed_out = 1'b1;
         end
      end else begin
         if (s.dis) m.mode = 0;
         else if (now == m.release_at) begin
            m.mode = 0;
            m.pulse = 1'b1;
         end
      end
      if (timed_out) m.err = 1'b1;
      else if (s.clr) m.err = 1'b0;
      return m;
   endfunction

   function automatic logic [3:0] outv(mdl_t m);
      return {m.mode != 0, m.mode == 0, m.pulse, m.err};
   endfunction

   task automatic tick(bit rst, bit arm, bit dis, bit man, bit clr);
      stim_t s;
      exp_t  e;
      @(posedge clk);
      #1;
      s = '{rst: rst, arm: arm, dis: dis, man: man, sync: g_sync, link: g_link,
            clr: clr, dly: g_dly, tmo: g_tmo};
      reset = rst;
      b1.arm = arm;  b1.disarm = dis;  b1.manual_req = man;  b1.clear_err = clr;
      b1.sync_in = g_sync;  b1.link_ready = g_link;
      b1.delay = 16'(g_dly);  b1.timeout = g_tmo;
      b0.arm = arm;  b0.disarm = dis;  b0.manual_req = man;  b0.clear_err = clr;
      b0.sync_in = g_sync;  b0.link_ready = g_link;
      b0.delay = 16'(g_dly);  b0.timeout = g_tmo;
      m1 = step(m1, 1'b1, cyc_n, s);
      m0 = step(m0, 1'b0, cyc_n, s);
      e.due = cyc_n + 1;
      e.e1 = outv(m1);
      e.e0 = outv(m0);
      sb.push_back(e);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(string name, logic [3:0] act, logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got{armed,dp_en,pulse,err}=%b want=%b",
                  name, cyc_n, act, exp);
      end
   endtask

   // Monitor: compares each DUT's registered outputs against the entry due this cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0 && sb[0].due == cyc_n) begin
            e = sb.pop_front();
            check("ext_sync1", {b1.armed, b1.datapath_en, b1.sync_pulse, b1.timeout_err}, e.e1);
            check("ext_sync0", {b0.armed, b0.datapath_en, b0.sync_pulse, b0.timeout_err}, e.e0);
         end
      end
   end

   initial begin
      b1.arm = 0; b1.disarm = 0; b1.manual_req = 0; b1.clear_err = 0;
      b1.sync_in = 1; b1.link_ready = 1; b1.delay = 0; b1.timeout = 0;
      b0.arm = 0; b0.disarm = 0; b0.manual_req = 0; b0.clear_err = 0;
      b0.sync_in = 1; b0.link_ready = 1; b0.delay = 0; b0.timeout = 0;
      m1 = '{mode: 0, armed_cycles: 0, release_at: 0, prev_sync: 1'b1, pulse: 1'b0, err: 1'b0};
      m0 = m1;

      // sync_in high through reset, then armed: no trigger until a fresh rising edge
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      g_sync = 1'b0; idle(1);
      g_sync = 1'b1; idle(3);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      g_sync = 1'b0; idle(2);

      // delay=5 manual trigger
      g_dly = 5;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(8);

      // timeout=100 then clear
      g_dly = 0; g_tmo = 100;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(104);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);

      // disarm against trigger, then disarm in DELAY
      g_tmo = 0;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(2);
      g_dly = 5;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);

      // link down blocks both trigger kinds
      g_dly = 0;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      g_link = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      g_sync = 1'b1; idle(2);
      g_link = 1'b1; idle(2);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      g_sync = 1'b0; idle(2);

      // reset in the middle of a delay countdown
      g_dly = 10;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);

      // arm with disarm in IDLE; trigger on the timeout cycle; clear on the timeout cycle
      g_dly = 0;
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      g_tmo = 4;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
      g_tmo = 3;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) g_sync = ~g_sync;
         g_link = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) g_dly = $urandom_range(0, 6);
         if ($urandom_range(0, 31) == 0)
            g_tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
         tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
              $urandom_range(0, 19) == 0);
      end

      repeat (3) @(posedge clk);
      #3;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_sync_ctrl.md
AD_IP_JESD204_TPL_DAC_SYNC_CTRL -- requirements
Module: ad_ip_jesd204_tpl_dac_sync_ctrl

Interface
REQ-001: Parameter EXT_SYNC, default 1; 1 = sync_in may trigger, 0 = only manual_req triggers.
REQ-002: Parameter DELAY_WIDTH, default 16; width of the delay input.
REQ-003: Parameter TIMEOUT_WIDTH, default 32; width of the timeout input.
REQ-004: Port clk, input, 1: link clock; the block has one clock, and all logic is rising-edge clk.
REQ-005: Port reset, input, 1: synchronous, active-high reset.
REQ-006: Port arm, input, 1: single-cycle arm request.
REQ-007: Port disarm, input, 1: single-cycle disarm request.
REQ-008: Port manual_req, input, 1: single-cycle software trigger.
REQ-009: Port sync_in, input, 1: external sync level, already in the clk domain; its rising edge is the trigger.
REQ-010: Port link_ready, input, 1: triggers are honoured only while this is 1.
REQ-011: Port delay, input, DELAY_WIDTH: number of cycles from trigger to release.
REQ-012: Port timeout, input, TIMEOUT_WIDTH: maximum cycles spent in ARMED; 0 disables the timeout.
REQ-013: Port clear_err, input, 1: clears timeout_err.
REQ-014: Port armed, output, 1: high in ARMED or DELAY.
REQ-015: Port datapath_en, output, 1: 1 lets DAC data pass; 0 forces the datapath to zero output.
REQ-016: Port sync_pulse, output, 1: single-cycle DDS/phase reset strobe.
REQ-017: Port timeout_err, output, 1: sticky armed-timeout flag.

Function
REQ-018: States are IDLE, ARMED and DELAY, and all outputs shall be registered.
REQ-019: In IDLE, datapath_en=1 and armed=0.
REQ-020: In ARMED and DELAY, datapath_en=0 and armed=1.
REQ-021: Trigger = link_ready & (manual_req | (EXT_SYNC & sync_in & ~sync_in_d)); sync_in_d is sync_in delayed by one clk.
REQ-022: From IDLE, arm moves to ARMED and clears the timeout counter; all other inputs are ignored in IDLE.
REQ-023: In ARMED, a trigger with delay==0 returns to IDLE, with sync_pulse=1 and datapath_en=1 on the next edge (latency 1).
REQ-024: In ARMED, a trigger with delay=D>0 enters DELAY and loads the counter with D-1.
REQ-025: In DELAY, the counter decrements each cycle.
REQ-026: When the DELAY counter is 0, the block returns to IDLE with sync_pulse=1; sync_pulse and the datapath_en rise occur exactly D+1 cycles after the trigger edge.
REQ-027: sync_pulse shall be exactly one cycle wide and shall only be asserted on exit from ARMED/DELAY via a trigger.
REQ-028: disarm in ARMED or DELAY returns to IDLE on the next edge, with no sync_pulse and timeout_err unchanged.
REQ-029: disarm has priority over a trigger and over the timeout in the same cycle.
REQ-030: arm and disarm asserted together in IDLE leave the block in IDLE.
REQ-031: arm in ARMED restarts the timeout counter; arm in DELAY is ignored.
REQ-032: Triggers in DELAY are ignored; the delay value is sampled only at the trigger.
REQ-033: With timeout=T≠0, the ARMED cycle counter saturates and is compared against T.
REQ-034: When T cycles have been spent in ARMED with no trigger or disarm, the block returns to IDLE and sets timeout_err=1, with no sync_pulse.
REQ-035: A trigger in the same cycle as the timeout wins.
REQ-036: clear_err clears timeout_err; if it coincides with a new timeout event, set wins.
REQ-037: With link_ready=0, a sync_in edge is lost, not queued.

Reset
REQ-038: On reset, state=IDLE, datapath_en=1, armed=0, sync_pulse=0, timeout_err=0, and all counters are 0.
REQ-039: On reset, sync_in_d=1, so a sync_in held high through reset produces no trigger.
REQ-040: reset asserted in ARMED or DELAY aborts to the reset values on the next edge, with no sync_pulse.

Verification
REQ-041: Delay=0 trigger: arm, then a sync_in rising edge at cycle T with link_ready=1 -> sync_pulse high for only cycle T+1, datapath_en 0→1 at T+1, armed 1→0 at T+1.
REQ-042: Delay=5 trigger: delay=5, arm, manual_req at cycle T -> datapath_en=0 through T+5, sync_pulse and datapath_en=1 at T+6.
REQ-043: Timeout: timeout=100, arm, no trigger -> return to IDLE exactly 100 cycles after ARMED entry, timeout_err=1, no sync_pulse; clear_err -> timeout_err=0 next cycle.
REQ-044: Disarm vs trigger: disarm and manual_req in the same ARMED cycle -> IDLE, sync_pulse never asserted; disarm in DELAY -> IDLE, no pulse.
REQ-045: Blocked triggers: EXT_SYNC=0 with a sync_in edge, or link_ready=0 with a trigger -> remains ARMED; sync_in high across reset -> no trigger after arm until the next rising edge.
REQ-046: Reset mid-DELAY: reset asserted at DELAY count 3 -> all outputs at reset values next cycle, no sync_pulse.
